// File: rtl/cfi_pkg.sv
// Shared CFI log types: per-class flag mask, log entry layout and the
// overflow-policy encoding used by the commit-side log queue.
package cfi_pkg;

  typedef struct packed {
    logic branch;
    logic jump;
    logic call;
    logic ret;
  } cfi_flags_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    cfi_flags_t  flags;
  } cfi_log_t;

  typedef enum logic {
    CFI_STALL = 1'b0,
    CFI_DROP  = 1'b1
  } cfi_overflow_e;

  // An entry survives the filter when any of its class bits is enabled.
  function automatic logic flags_hit(cfi_flags_t flags, cfi_flags_t mask);
    return (flags & mask) != '0;
  endfunction

endpackage

// File: rtl/cfi_log_compact.sv
// Filters the per-port CFI entries and packs the surviving ones into the
// low output lanes in ascending port order, reporting how many survived.
module cfi_log_compact
  import cfi_pkg::*;
#(
  parameter int NrPorts = 2
) (
  input  logic [NrPorts-1:0]             log_valid_i,
  input  cfi_log_t [NrPorts-1:0]         log_i,
  input  cfi_flags_t                     filter_i,
  output cfi_log_t [NrPorts-1:0]         comp_o,
  output logic [$clog2(NrPorts+1)-1:0]   kept_cnt_o
);

  localparam int KW = $clog2(NrPorts + 1);

  logic [NrPorts-1:0] kept;
  logic [KW-1:0]      prefix [NrPorts];

  for (genvar gi = 0; gi < NrPorts; gi++) begin : g_keep
    assign kept[gi] = log_valid_i[gi] && flags_hit(log_i[gi].flags, filter_i);
  end

  // prefix[k] is the output lane port k lands in if it is kept.
  always_comb begin
    logic [KW-1:0] run;
    run = '0;
    for (int k = 0; k < NrPorts; k++) begin
      prefix[k] = run;
      if (kept[k]) run = run + KW'(1);
    end
    kept_cnt_o = run;
  end

  always_comb begin
    comp_o = '0;
    for (int j = 0; j < NrPorts; j++) begin
      for (int k = 0; k < NrPorts; k++) begin
        if (kept[k] && prefix[k] == KW'(j)) comp_o[j] = log_i[k];
      end
    end
  end

endmodule

// File: rtl/cfi_log_queue.sv
// Multi-port CFI log queue: compacts filtered commit-side entries into a
// flop-array FIFO with either backpressure or drop-on-overflow behaviour.
module cfi_log_queue
  import cfi_pkg::*;
#(
  parameter int NrPorts  = 2,
  parameter int Depth    = 8,
  parameter int CntWidth = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  cfi_flags_t                   filter_i,
  input  logic                         drop_mode_i,
  input  logic [NrPorts-1:0]           log_valid_i,
  input  cfi_log_t [NrPorts-1:0]       log_i,
  output logic                         log_ready_o,
  output logic                         log_valid_o,
  output cfi_log_t                     log_o,
  input  logic                         log_ready_i,
  output logic [$clog2(Depth+1)-1:0]   usage_o,
  output logic [CntWidth-1:0]          drop_cnt_o
);

  localparam int PW = $clog2(Depth);
  localparam int UW = $clog2(Depth + 1);
  localparam int KW = $clog2(NrPorts + 1);

  cfi_log_t [NrPorts-1:0] comp;
  logic [KW-1:0]          kept_cnt;

  cfi_log_t               mem_reg [Depth];
  logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0]          wr_idx [NrPorts];
  logic [UW-1:0]          usage_reg, usage_next;
  logic [UW-1:0]          free_slots, kept_u, wr_cnt, drop_now;
  logic [CntWidth-1:0]    drop_cnt_reg, drop_cnt_next;
  logic [CntWidth:0]      drop_sum;
  logic                   pop;

  cfi_log_compact #(
    .NrPorts (NrPorts)
  ) u_compact (
    .log_valid_i (log_valid_i),
    .log_i       (log_i),
    .filter_i    (filter_i),
    .comp_o      (comp),
    .kept_cnt_o  (kept_cnt)
  );

  for (genvar gi = 0; gi < NrPorts; gi++) begin : g_idx
    assign wr_idx[gi] = wr_ptr_reg + PW'(gi);
  end

  // Free space comes from the registered count only; a same-cycle pop
  // never makes room for this cycle's writes.
  always_comb begin
    free_slots  = UW'(Depth) - usage_reg;
    kept_u      = UW'(kept_cnt);
    wr_cnt      = '0;
    drop_now    = '0;
    log_ready_o = 1'b1;
    if (flush_i) begin
      wr_cnt   = '0;
      drop_now = '0;
    end else if (cfi_overflow_e'(drop_mode_i) == CFI_DROP) begin
      if (kept_u > free_slots) begin
        wr_cnt   = free_slots;
        drop_now = kept_u - free_slots;
      end else begin
        wr_cnt = kept_u;
      end
    end else begin
      log_ready_o = free_slots >= UW'(NrPorts);
      if (log_ready_o) wr_cnt = kept_u;
    end
    pop        = log_valid_o && log_ready_i && !flush_i;
    usage_next = usage_reg + wr_cnt - UW'(pop);
    drop_sum   = {1'b0, drop_cnt_reg} + (CntWidth+1)'(drop_now);
    drop_cnt_next = drop_sum[CntWidth] ? '1 : drop_sum[CntWidth-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      usage_reg    <= '0;
      drop_cnt_reg <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      usage_reg  <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_reg + PW'(wr_cnt);
      rd_ptr_reg   <= rd_ptr_reg + PW'(pop);
      usage_reg    <= usage_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      for (int j = 0; j < NrPorts; j++) begin
        if (UW'(j) < wr_cnt) mem_reg[wr_idx[j]] <= comp[j];
      end
    end
  end

  assign log_o       = mem_reg[rd_ptr_reg];
  assign log_valid_o = usage_reg != '0;
  assign usage_o     = usage_reg;
  assign drop_cnt_o  = drop_cnt_reg;

endmodule

// File: tb/tb_cfi_log_queue.sv
// Directed bench for cfi_log_queue (NrPorts=2, Depth=8): fill/stall, drop
// overflow, filtering, wrap-around ordering, flush and reset.
module tb_cfi_log_queue;
  import cfi_pkg::*;

  localparam logic [3:0] F_BR   = 4'b1000;
  localparam logic [3:0] F_JMP  = 4'b0100;
  localparam logic [3:0] F_CALL = 4'b0010;
  localparam logic [3:0] F_RET  = 4'b0001;

  logic            clk = 1'b0;
  logic            rst, flush, drop_mode, rdy_i;
  cfi_flags_t      filter;
  logic [1:0]      vin;
  cfi_log_t [1:0]  log_in;
  logic            log_ready, log_valid;
  cfi_log_t        log_out;
  logic [3:0]      usage;
  logic [15:0]     drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int q[$];

  always #5 clk = ~clk;

  cfi_log_queue #(.NrPorts(2), .Depth(8), .CntWidth(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .filter_i    (filter),
    .drop_mode_i (drop_mode),
    .log_valid_i (vin),
    .log_i       (log_in),
    .log_ready_o (log_ready),
    .log_valid_o (log_valid),
    .log_o       (log_out),
    .log_ready_i (rdy_i),
    .usage_o     (usage),
    .drop_cnt_o  (drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic cfi_log_t mk(input int pc, input logic [3:0] fl);
    cfi_log_t e;
    e.pc     = 32'(pc);
    e.target = 32'(pc) + 32'h1000;
    e.flags  = cfi_flags_t'(fl);
    return e;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One model-checked cycle in backpressure mode with filter 4'b1110.
  task automatic model_cycle();
    logic exp_rdy;
    #1;
    exp_rdy = (8 - q.size()) >= 2;
    check("wrap_ready", log_ready, exp_rdy);
    check("wrap_usage", usage, q.size());
    if (q.size() > 0) check("wrap_head", log_out.pc, q[0]);
    @(posedge clk);
    if (q.size() > 0 && rdy_i) void'(q.pop_front());
    if (exp_rdy)
      for (int k = 0; k < 2; k++)
        if (vin[k] && ((log_in[k].flags & filter) != '0)) q.push_back(int'(log_in[k].pc));
    #1;
    $display("wrap cycle: usage=%0d head=%0d", usage, log_out.pc);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; drop_mode = 1'b0; rdy_i = 1'b0;
    filter = cfi_flags_t'(4'hF); vin = '0; log_in = '0;
    cycle(); cycle();
    check("rst_usage", usage, 0);
    check("rst_valid", log_valid, 0);
    check("rst_drop", drop_cnt, 0);
    rst = 1'b0;

    // Fill to capacity with call entries, consumer stalled.
    for (int i = 0; i < 4; i++) begin
      vin = 2'b11;
      log_in[0] = mk(2*i, F_CALL);
      log_in[1] = mk(2*i + 1, F_CALL);
      #1;
      check("fill_ready", log_ready, 1);
      cycle();
      $display("fill push %0d: usage=%0d", i, usage);
    end
    log_in[0] = mk(8, F_CALL);
    log_in[1] = mk(9, F_CALL);
    #1;
    check("full_usage", usage, 8);
    check("full_ready", log_ready, 0);
    cycle();
    check("full_nowrite", usage, 8);
    check("full_head", log_out.pc, 0);
    vin = '0; rdy_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("drain_order", log_out.pc, k);
      check("drain_valid", log_valid, 1);
      cycle();
      $display("drain pop %0d", k);
    end
    check("drain_empty", usage, 0);
    check("drain_valid0", log_valid, 0);
    rdy_i = 1'b0;

    // Drop mode: usage 7, then two kept entries -> one stored, one dropped.
    drop_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vin = (i == 3) ? 2'b01 : 2'b11;
      log_in[0] = mk(100 + 2*i, F_CALL);
      log_in[1] = mk(101 + 2*i, F_CALL);
      cycle();
    end
    check("drop_pre_usage", usage, 7);
    vin = 2'b11;
    log_in[0] = mk(200, F_CALL);
    log_in[1] = mk(201, F_CALL);
    #1;
    check("drop_ready", log_ready, 1);
    cycle();
    $display("drop push: usage=%0d drop=%0d", usage, drop_cnt);
    check("drop_usage", usage, 8);
    check("drop_cnt1", drop_cnt, 1);

    // Full with simultaneous pop and a single push: push is dropped.
    vin = 2'b01; log_in[0] = mk(300, F_CALL); rdy_i = 1'b1;
    cycle();
    $display("pop+drop: usage=%0d drop=%0d", usage, drop_cnt);
    check("popdrop_usage", usage, 7);
    check("popdrop_cnt", drop_cnt, 2);
    vin = '0;
    for (int k = 0; k < 7; k++) begin
      #1;
      check("drop_order", log_out.pc, (k < 6) ? 101 + k : 200);
      cycle();
    end
    check("drop_empty", usage, 0);
    rdy_i = 1'b0; drop_mode = 1'b0;

    // Filter return only: branch on port 0 discarded, not counted.
    filter = cfi_flags_t'(F_RET);
    vin = 2'b11;
    log_in[0] = mk(400, F_BR);
    log_in[1] = mk(401, F_RET);
    cycle();
    vin = '0;
    $display("filter push: usage=%0d head=%0d", usage, log_out.pc);
    check("filt_usage", usage, 1);
    check("filt_head", log_out.pc, 401);
    check("filt_drop", drop_cnt, 2);
    rdy_i = 1'b1;
    cycle();
    check("filt_empty", usage, 0);

    // Mixed push/pop with pointer wrap, checked against a queue model.
    filter = cfi_flags_t'(4'b1110);
    rdy_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vin = (i % 3 == 0) ? 2'b11 : 2'b01;
      log_in[0] = mk(500 + 2*i, F_JMP);
      log_in[1] = mk(501 + 2*i, (i % 5 == 4) ? F_RET : F_BR);
      model_cycle();
    end
    vin = '0;
    for (int i = 0; i < 10; i++) model_cycle();
    check("wrap_empty", usage, 0);
    rdy_i = 1'b0;

    // Flush with usage 5 and valid inputs; drop count survives.
    filter = cfi_flags_t'(4'hF);
    for (int i = 0; i < 3; i++) begin
      vin = (i == 2) ? 2'b01 : 2'b11;
      log_in[0] = mk(600 + 2*i, F_CALL);
      log_in[1] = mk(601 + 2*i, F_CALL);
      cycle();
    end
    check("flush_pre", usage, 5);
    flush = 1'b1; vin = 2'b11; rdy_i = 1'b1;
    #1;
    check("flush_ready", log_ready, 1);
    cycle();
    flush = 1'b0; vin = '0; rdy_i = 1'b0;
    $display("flush: usage=%0d drop=%0d", usage, drop_cnt);
    check("flush_usage", usage, 0);
    check("flush_valid", log_valid, 0);
    check("flush_drop", drop_cnt, 2);
    vin = 2'b01; log_in[0] = mk(700, F_CALL);
    cycle();
    vin = '0;
    check("postflush_head", log_out.pc, 700);
    check("postflush_usage", usage, 1);

    rst = 1'b1;
    cycle();
    rst = 1'b0;
    $display("reset: usage=%0d drop=%0d", usage, drop_cnt);
    check("rst2_drop", drop_cnt, 0);
    check("rst2_usage", usage, 0);
    check("rst2_valid", log_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cfi_log_queue.md
CFI_LOG_QUEUE -- requirements
Module: cfi_log_queue

Interface
REQ-001 SHALL have parameter NrPorts, default 2, number of commit-side CFI log ports (1..4).
REQ-002 SHALL have parameter Depth, default 8, queue entries (power of two, >= NrPorts, >= 2).
REQ-003 SHALL have parameter CntWidth, default 16, drop-counter width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush_i  input  1  discard all queued entries.
REQ-007 SHALL have port filter_i  input  cfi_flags_t  per-class enable mask (branch/jump/call/return).
REQ-008 SHALL have port drop_mode_i  input  1  1 = drop on overflow, 0 = backpressure.
REQ-009 SHALL have port log_valid_i  input  NrPorts  per-port entry valid.
REQ-010 SHALL have port log_i  input  NrPorts x cfi_log_t  per-port entries.
REQ-011 SHALL have port log_ready_o  output  1  all-or-none acceptance of the current input set.
REQ-012 SHALL have port log_valid_o  output  1  head entry valid.
REQ-013 SHALL have port log_o  output  cfi_log_t  head entry.
REQ-014 SHALL have port log_ready_i  input  1  consumer accepts head.
REQ-015 SHALL have port usage_o  output  $clog2(Depth+1)  current occupancy.
REQ-016 SHALL have port drop_cnt_o  output  CntWidth  saturating count of dropped entries.

Function
REQ-017 Port k SHALL be "kept" iff log_valid_i[k] and (log_i[k].flags & filter_i) != 0; non-kept entries are silently discarded and never counted as drops.
REQ-018 Kept entries SHALL be written in ascending port order into consecutive slots starting at the tail pointer, with no holes.
REQ-019 Backpressure mode: log_ready_o SHALL be 1 iff Depth - usage_o >= NrPorts, with usage_o taken from the registered count (a same-cycle pop does not add free space).
REQ-020 Backpressure mode: when log_ready_o = 0, no entry SHALL be written that cycle, and the producer holds its inputs.
REQ-021 Drop mode: log_ready_o SHALL be 1 at all times; if kept > Depth - usage_o, the lowest-index kept entries fill the free slots and the rest SHALL be dropped.
REQ-022 drop_cnt_o SHALL increase by the number dropped that cycle and saturate at all-ones.
REQ-023 log_valid_o SHALL equal (usage_o != 0); log_o SHALL be the entry at the head pointer, driven from storage with no combinational path from log_i.
REQ-024 A pop SHALL occur when log_valid_o and log_ready_i; the head advances by one.
REQ-025 Push and pop in one cycle SHALL both take effect; next usage = usage + written - popped.
REQ-026 Minimum latency input-to-log_valid_o SHALL be 1 cycle (written on edge N, visible after edge N).
REQ-027 Pointers SHALL wrap modulo Depth.
REQ-028 flush_i SHALL, on the next edge, zero usage and both pointers and ignore that cycle's inputs and pop; it SHALL NOT clear drop_cnt_o.
REQ-029 While flush_i = 1, log_ready_o SHALL be 1 and the ignored inputs SHALL NOT count as drops.

Reset
REQ-030 On rst_i = 1 at an edge: usage_o = 0, pointers = 0, drop_cnt_o = 0, log_valid_o = 0; reset dominates flush_i.
REQ-031 Storage contents need no reset; log_o is don't-care while log_valid_o = 0.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries with no partial write.

Structure
REQ-033 cfi_flags_t and cfi_log_t SHALL stay in cfi_pkg; cfi_pkg SHALL gain cfi_overflow_e (CFI_STALL, CFI_DROP) for drop_mode_i encoding.
REQ-034 Filter and port compaction SHALL be a combinational sub-module cfi_log_compact (outputs compacted entries and kept count).
REQ-035 Storage SHALL be a flop array indexed by the pointers; no memory macro.

Verification
REQ-036 NrPorts=2, Depth=8: push 4 cycles of 2 call entries, filter all-ones, log_ready_i=0 -> usage 8, log_ready_o=0 in cycle 5, no write.
REQ-037 Drop mode, usage 7, 2 kept entries -> port 0 entry stored, usage 8, drop_cnt_o +1.
REQ-038 filter_i = return only; port0 branch, port1 return -> only port1 stored, at tail slot, drop_cnt_o unchanged.
REQ-039 usage 8, simultaneous pop and drop-mode push of 1 -> entry dropped, usage 7, drop_cnt_o +1.
REQ-040 16 push/pop cycles with pointers wrapping -> log_o order matches input order exactly.
REQ-041 flush_i with usage 5 and valid inputs -> usage 0 next cycle, log_valid_o 0, drop_cnt_o unchanged; rst_i then -> drop_cnt_o 0.
